manchester_frame_rx: RTL and testbench
======================================

# manchester_frame_rx

Oversampling Manchester frame receiver: the receive end of the Manchester link driven by `manchester_encoder`. It recovers bit timing from mid-bit transitions on a raw line sampled at `OVS` clocks per bit, hunts for a sync word, and assembles payload bits into bytes. Bytes are delivered on a valid/ready stream with end-of-frame marking. It sits between the line input and the byte-level consumer, replacing the single-bit `manchester_decoder` on links that carry framed traffic.

## Interface
- `OVS`, 8: clocks per bit period; even, ≥4.
- `SYNC_WORD`, 8'hD5: start-of-frame delimiter, MSB first.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-low reset.
- `manchester_in` in 1: raw line, asynchronous to `clk`.
- `m_data` out 8: received byte.
- `m_valid` out 1: `m_data`/`m_last` valid.
- `m_ready` in 1: consumer accepts when `m_valid && m_ready`.
- `m_last` out 1: byte is the final byte of its frame.
- `in_frame` out 1: high from sync match until frame end.
- `frame_err` out 1: one-cycle pulse on code violation or truncated final byte.
- `overrun` out 1: one-cycle pulse when a byte is dropped.

## Operation
- Encoding, identical to the encoder: 1 = low→high at mid-bit, 0 = high→low. The decoded bit is the line level after the mid-bit edge.
- Line input passes through a 2-FF synchronizer. The edge detector compares the synchronized sample with its previous value.
- `phase` counter: clocks since the last accepted mid-bit edge; saturates at 5·OVS/4.
- Edge classification by `phase` value (OVS=8 values in brackets):
  - ≥3·OVS/4 [6..]: mid-bit edge. Shift bit, clear `phase` to 0.
  - OVS/4..3·OVS/4−1 [2..5]: bit-boundary edge, ignored.
  - <OVS/4 [0..1]: code violation.
- Timeout: `phase` reaches 5·OVS/4 [10] with no mid-bit edge.
- IDLE: the first edge is taken as a mid-bit edge: `phase`←0, no bit shifted → HUNT.
- HUNT: shift each bit into an 8-bit window. Window == `SYNC_WORD` → DATA, bit count 0, `in_frame`←1. Violation or timeout → IDLE silently.
- DATA: shift bits MSB first. On the 8th bit the byte moves to the staging register. Any byte already staged is first pushed with last=0.
- Frame end (timeout in DATA): push the staged byte with last=1. If the bit count ≠0, the partial byte is discarded and `frame_err` pulses. `in_frame`←0 → IDLE.
- Violation in DATA: push the staged byte with last=1, pulse `frame_err` → IDLE.
- Frame end or violation with no byte staged: nothing pushed, `frame_err` pulses. Applies to an empty payload and to a violation before the first byte.
- Push into the single output register:
  - Accepted if the register is empty, or if it is handshaking in the same cycle.
  - Otherwise the pushed byte is dropped and `overrun` pulses; the output register is unchanged.
- Output register holds `m_data`/`m_last` stable while `m_valid && !m_ready`.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_last`=0, `in_frame`=0, `frame_err`=0, `overrun`=0. State IDLE, `phase`=0, synchronizer=1.
- Line edge to detection: 3 clocks (2 sync + 1 edge compare).
- `in_frame` rises the cycle after the last sync-word mid-bit edge is detected.
- A byte reaches `m_valid` one clock after its push event. The push event is the next byte's 8th mid-bit edge, or the frame-end/violation cycle.
- Last byte latency: at most 5·OVS/4 + 4 clocks after its final mid-bit line edge.
- Reset asserted mid-frame: all state clears immediately. No partial byte or last flag is emitted after release.

## Structure
- Shared package `manchester_pkg`: FSM state enum (IDLE, HUNT, DATA) and the encoding polarity constant. The encoder and this block share both.
- Thresholds OVS/4, 3·OVS/4 and 5·OVS/4 are local constants derived from `OVS`.
- One sub-module, `manchester_edge_detect`: 2-FF synchronizer plus rise/fall/any-edge pulses.

## Test plan
- Clean frame, OVS=8: 16-bit 1010… preamble, D5, payload 0x3C 0xA7, then idle. Expect 0x3C (last=0), 0xA7 (last=1), no error pulses, `in_frame` low after timeout.
- Jitter: mid-bit edges displaced ±1 clock on every bit. Same bytes as the clean frame, no `frame_err`.
- Truncation: payload 0x55 plus 3 extra bits, then idle. Expect 0x55 with last=1 and one `frame_err` pulse.
- Overrun: `m_ready`=0 throughout a 3-byte frame. Expect the first byte held on `m_data`, two `overrun` pulses, output unchanged.
- Violation: an extra edge at phase 1 during the 2nd payload byte. Expect byte 1 with last=1, `frame_err` pulse, FSM back in IDLE.
- Reset mid-frame: drive `rst` low after 4 payload bits. All outputs go to 0. Re-sending the clean frame after release yields 0x3C/0xA7 normally.

Source files
------------

// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester encoder / frame receiver pair.
//   mch_state_t   : receiver framing FSM states
//   ONE_IS_RISING : line polarity; a logic 1 is a low->high mid-bit transition
package manchester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for any line activity
    ST_HUNT = 2'd1,  // bit-locked, searching for the sync word
    ST_DATA = 2'd2   // inside a frame, assembling payload bytes
  } mch_state_t;

  // Polarity shared with manchester_encoder: 1 = rising edge at mid-bit,
  // 0 = falling edge at mid-bit.
  localparam logic ONE_IS_RISING = 1'b1;

endpackage

// File: rtl/manchester_edge_detect.sv
// Two-flop synchronizer for the raw Manchester line plus edge pulses.
//   clk, rst  : clock, asynchronous active-low reset
//   line      : raw line, asynchronous to clk
//   rise      : synchronized line went 0 -> 1 this cycle
//   fall      : synchronized line went 1 -> 0 this cycle
//   any_edge  : rise | fall
module manchester_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic rise,
  output logic fall,
  output logic any_edge
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // NOTE: the synchronizer resets to 1, the idle line level, so releasing
  // reset on a quiet line never manufactures a spurious edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the previous
      // value of its neighbour, which is what forms the shift chain.
      sync1_q <= line;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise     = sync2_q & ~prev_q;
  assign fall     = ~sync2_q & prev_q;
  assign any_edge = rise | fall;

endmodule

// File: rtl/manchester_frame_rx.sv
// Oversampling Manchester frame receiver.
// Recovers bit timing from mid-bit transitions, hunts for SYNC_WORD and
// assembles the following payload bits (MSB first) into bytes, delivered on a
// single-register valid/ready stream with end-of-frame marking.
//   clk, rst      : clock, asynchronous active-low reset
//   manchester_in : raw line, asynchronous to clk
//   m_data/m_last : received byte / final byte of its frame
//   m_valid       : m_data/m_last valid; accepted when m_valid && m_ready
//   m_ready       : consumer ready
//   in_frame      : high from sync match until frame end
//   frame_err     : one-cycle pulse on code violation or truncated final byte
//   overrun       : one-cycle pulse when a byte is dropped (output busy)
module manchester_frame_rx
  import manchester_pkg::*;
#(
  parameter int         OVS       = 8,
  parameter logic [7:0] SYNC_WORD = 8'hD5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       manchester_in,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       in_frame,
  output logic       frame_err,
  output logic       overrun
);

  localparam int              PH_W   = $clog2(5 * OVS / 4 + 2);
  localparam logic [PH_W-1:0] PH_QTR = PH_W'(OVS / 4);
  localparam logic [PH_W-1:0] PH_MID = PH_W'(3 * OVS / 4);
  localparam logic [PH_W-1:0] PH_TMO = PH_W'(5 * OVS / 4);

  logic rise, fall, any_edge;

  manchester_edge_detect u_edge (
    .clk      (clk),
    .rst      (rst),
    .line     (manchester_in),
    .rise     (rise),
    .fall     (fall),
    .any_edge (any_edge)
  );

  // ---------------------------------------------------------------- state
  mch_state_t      state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      stg_data_q, stg_data_d;
  logic            stg_valid_q, stg_valid_d;
  logic            in_frame_d, frame_err_d, overrun_d;
  logic [7:0]      m_data_d;
  logic            m_valid_d, m_last_d;

  // phase_q holds the clocks completed since the last accepted edge; the
  // current cycle is one more, so an edge exactly one bit later sees
  // elapsed == OVS.
  logic [PH_W-1:0] elapsed;
  logic            bit_val;
  logic            mid_edge, violation, timeout;
  logic [7:0]      shifted;
  logic            push, push_last, accept;
  logic [7:0]      push_data;

  assign elapsed   = phase_q + PH_W'(1);
  assign bit_val   = ONE_IS_RISING ? rise : fall;
  assign mid_edge  = any_edge && (elapsed >= PH_MID);
  assign violation = any_edge && (elapsed < PH_QTR);
  assign timeout   = !any_edge && (elapsed == PH_TMO);
  assign shifted   = {shreg_q[6:0], bit_val};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_d     = state_q;
    phase_d     = (phase_q == PH_TMO) ? phase_q : phase_q + PH_W'(1);
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    stg_data_d  = stg_data_q;
    stg_valid_d = stg_valid_q;
    in_frame_d  = in_frame;
    frame_err_d = 1'b0;
    push        = 1'b0;
    push_data   = stg_data_q;
    push_last   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // First edge is taken as mid-bit purely to seed the phase counter.
        if (any_edge) begin
          phase_d = '0;
          shreg_d = '0;
          state_d = ST_HUNT;
        end
      end

      ST_HUNT: begin
        if (mid_edge) begin
          phase_d = '0;
          shreg_d = shifted;
          if (shifted == SYNC_WORD) begin
            state_d    = ST_DATA;
            bit_cnt_d  = '0;
            in_frame_d = 1'b1;
          end
        end else if (violation || timeout) begin
          state_d = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (mid_edge) begin
          phase_d   = '0;
          shreg_d   = shifted;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            // A completed byte waits in staging until we know whether it
            // is the last one; the one it displaces is therefore not last.
            push        = stg_valid_q;
            push_last   = 1'b0;
            stg_data_d  = shifted;
            stg_valid_d = 1'b1;
          end
        end else if (violation || timeout) begin
          push        = stg_valid_q;
          push_last   = 1'b1;
          stg_valid_d = 1'b0;
          frame_err_d = violation || !stg_valid_q || (bit_cnt_q != 3'd0);
          in_frame_d  = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Single output register: a push lands only if the slot is free now or is
  // being emptied by a handshake this very cycle.
  always_comb begin
    accept    = push && (!m_valid || m_ready);
    m_valid_d = m_valid && !m_ready;
    m_data_d  = m_data;
    m_last_d  = m_last;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = push_data;
      m_last_d  = push_last;
    end
    overrun_d = push && !accept;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      stg_data_q  <= '0;
      stg_valid_q <= 1'b0;
      in_frame    <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      stg_data_q  <= stg_data_d;
      stg_valid_q <= stg_valid_d;
      in_frame    <= in_frame_d;
      frame_err   <= frame_err_d;
      overrun     <= overrun_d;
      m_valid     <= m_valid_d;
      m_data      <= m_data_d;
      m_last      <= m_last_d;
    end
  end

endmodule

// File: tb/tb_manchester_frame_rx.sv
// Self-checking bench for manchester_frame_rx: directed frames from the test
// plan plus randomized frames, each compared against a frame-level model
// (expected bytes, last flag, error and overrun pulse counts).
module tb_manchester_frame_rx;

  localparam int         OVS  = 8;
  localparam logic [7:0] SYNC = 8'hD5;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       manchester_in = 1'b1;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_valid, m_last, in_frame, frame_err, overrun;

  always #5 clk = ~clk;

  manchester_frame_rx #(.OVS(OVS), .SYNC_WORD(SYNC)) dut (
    .clk           (clk),
    .rst           (rst),
    .manchester_in (manchester_in),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .in_frame      (in_frame),
    .frame_err     (frame_err),
    .overrun       (overrun)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------- monitor
  logic [8:0] got_q[$];          // {last, data} of every accepted byte
  int         err_total     = 0;
  int         ovr_total     = 0;
  int         in_frame_cyc  = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (m_valid && m_ready) got_q.push_back({m_last, m_data});
      if (frame_err) err_total++;
      if (overrun)   ovr_total++;
      if (in_frame)  in_frame_cyc++;
    end
  end

  // ---------------------------------------------------------- line stimulus
  logic line_seq[$];             // one line level per clock

  task automatic add_level(input logic v, input int n);
    for (int i = 0; i < n; i++) line_seq.push_back(v);
  endtask

  // Bit cell of OVS clocks; the mid-bit transition is moved by j in -1..+1.
  // With glitch set, the line flips back one clock after the mid-bit edge.
  task automatic add_bit(input logic b, input bit jit, input bit glitch);
    int j;
    j = jit ? int'($urandom_range(0, 2)) - 1 : 0;
    add_level(~b, OVS / 2 + j);
    if (glitch) begin
      add_level(b, 1);
      add_level(~b, 1);
    end else begin
      add_level(b, OVS / 2 - j);
    end
  endtask

  task automatic build_frame(input byte_q_t payload, input int extra, input bit jit,
                             input int viol_bit, input int stop_bit);
    int k;
    line_seq.delete();
    for (int i = 0; i < 16; i++) add_bit((i % 2) == 0, jit, 1'b0);
    for (int i = 7; i >= 0; i--) add_bit(SYNC[i], jit, 1'b0);
    k = 0;
    foreach (payload[n]) begin
      for (int i = 7; i >= 0; i--) begin
        if (k == stop_bit) return;
        add_bit(payload[n][i], jit, k == viol_bit);
        if (k == viol_bit) return;
        k++;
      end
    end
    for (int e = 0; e < extra; e++) add_bit(1'($urandom_range(0, 1)), jit, 1'b0);
  endtask

  task automatic play();
    foreach (line_seq[i]) begin
      @(posedge clk);
      #1 manchester_in = line_seq[i];
    end
    @(posedge clk);
    #1 manchester_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame-level model: a violation after payload bit k leaves (k+1)/8 whole
  // bytes, the final one flagged last; any violation, empty payload or
  // leftover partial byte gives exactly one frame_err.
  task automatic run_frame(input string name, input byte_q_t payload, input int extra,
                           input bit jit, input int viol_bit);
    int base_q, base_err, base_ovr, base_if, n_exp, err_exp;
    base_q   = got_q.size();
    base_err = err_total;
    base_ovr = ovr_total;
    base_if  = in_frame_cyc;
    build_frame(payload, extra, jit, viol_bit, -1);
    play();
    idle(40);
    n_exp   = (viol_bit >= 0) ? (viol_bit + 1) / 8 : payload.size();
    err_exp = (viol_bit >= 0 || extra != 0 || payload.size() == 0) ? 1 : 0;
    check($sformatf("%s nbytes", name), got_q.size() - base_q, n_exp);
    for (int i = 0; i < n_exp; i++) begin
      if (base_q + i < got_q.size()) begin
        check($sformatf("%s data[%0d]", name, i), got_q[base_q + i][7:0], payload[i]);
        check($sformatf("%s last[%0d]", name, i), got_q[base_q + i][8], i == n_exp - 1);
      end
    end
    check($sformatf("%s frame_err", name), err_total - base_err, err_exp);
    check($sformatf("%s overrun", name), ovr_total - base_ovr, 0);
    check($sformatf("%s in_frame_seen", name), in_frame_cyc > base_if, 1);
    check($sformatf("%s in_frame_end", name), in_frame, 0);
  endtask

  // ---------------------------------------------------------- main
  initial begin
    byte_q_t pl;
    int      base_q, base_err, base_ovr;

    // Reset state
    #1;
    check("rst m_valid", m_valid, 0);
    check("rst m_data", m_data, 0);
    check("rst m_last", m_last, 0);
    check("rst in_frame", in_frame, 0);
    check("rst frame_err", frame_err, 0);
    check("rst overrun", overrun, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(5);

    pl = '{8'h3C, 8'hA7};
    run_frame("clean", pl, 0, 1'b0, -1);
    run_frame("jitter", pl, 0, 1'b1, -1);

    pl = '{8'h55};
    run_frame("trunc", pl, 3, 1'b0, -1);

    // Violation one clock after the 4th mid-bit edge of payload byte 2
    pl = '{8'h3C, 8'hA7};
    run_frame("viol", pl, 0, 1'b0, 11);

    // Overrun: consumer stalled for a whole 3-byte frame
    pl = '{8'h12, 8'h34, 8'h56};
    @(posedge clk);
    #1 m_ready = 1'b0;
    base_q   = got_q.size();
    base_err = err_total;
    base_ovr = ovr_total;
    build_frame(pl, 0, 1'b0, -1, -1);
    play();
    idle(40);
    check("ovr m_valid", m_valid, 1);
    check("ovr m_data", m_data, pl[0]);
    check("ovr m_last", m_last, pl.size() == 1);
    check("ovr overrun", ovr_total - base_ovr, pl.size() - 1);
    check("ovr frame_err", err_total - base_err, 0);
    check("ovr nbytes_stalled", got_q.size() - base_q, 0);
    @(posedge clk);
    #1 m_ready = 1'b1;
    idle(2);
    check("ovr nbytes_drained", got_q.size() - base_q, 1);
    if (got_q.size() > base_q) check("ovr drained", got_q[base_q], {1'b0, pl[0]});
    check("ovr m_valid_after", m_valid, 0);

    // Reset after four payload bits
    pl = '{8'h3C, 8'hA7};
    base_q   = got_q.size();
    base_err = err_total;
    build_frame(pl, 0, 1'b0, -1, 4);
    play();
    idle(1);
    check("mid in_frame", in_frame, 1);
    #1 rst = 1'b0;
    #1;
    check("mid rst m_valid", m_valid, 0);
    check("mid rst m_data", m_data, 0);
    check("mid rst m_last", m_last, 0);
    check("mid rst in_frame", in_frame, 0);
    check("mid rst frame_err", frame_err, 0);
    check("mid rst overrun", overrun, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(40);
    check("mid nbytes", got_q.size() - base_q, 0);
    check("mid frame_err", err_total - base_err, 0);
    run_frame("clean2", pl, 0, 1'b0, -1);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      int n, extra, viol;
      bit jit;
      n = $urandom_range(0, 4);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      jit   = 1'($urandom_range(0, 1));
      extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
      viol  = -1;
      if (n > 0 && $urandom_range(0, 3) == 0) begin
        viol  = $urandom_range(0, 8 * n - 1);
        extra = 0;
      end
      run_frame($sformatf("rand%0d", f), pl, extra, jit, viol);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
